// File: rtl/commit_stage_nport_pkg.sv
// Shared types for the N-port commit stage.
// Scoreboard entry, exception bundle and drain FSM enums.
package commit_stage_nport_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef enum logic [3:0] {
    ADD, SUB, CSR_READ, CSR_WRITE, CSR_SET,
    FENCE, FENCE_I, SFENCE_VMA
  } fu_op;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic            valid;
    fu_t             fu;
    fu_op            op;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    exception_t      ex;
    logic            chg_dom;
    logic [1:0]      data_dom;
  } scoreboard_entry_t;

  typedef enum logic [1:0] {IDLE, DRAIN, DOMFLUSH} commit_state_e;

  typedef enum logic [1:0] {SK_FENCE, SK_FENCE_I, SK_SFENCE} serial_kind_e;

  function automatic logic is_serial(fu_op op);
    return op inside {FENCE, FENCE_I, SFENCE_VMA};
  endfunction

  function automatic serial_kind_e to_kind(fu_op op);
    if (op == FENCE_I) return SK_FENCE_I;
    if (op == SFENCE_VMA) return SK_SFENCE;
    return SK_FENCE;
  endfunction

  // Entries that may only retire alone on port 0
  function automatic logic is_barrier(scoreboard_entry_t e);
    return (e.fu inside {STORE, CSR}) || e.chg_dom || is_serial(e.op);
  endfunction

  function automatic logic fu_simple(fu_t fu);
    return fu inside {ALU, LOAD, CTRL_FLOW, MULT};
  endfunction

endpackage

// File: rtl/commit_stage_nport_drain.sv
// Drain FSM for fences and domain changes.
// Holds state, latched fence kind, drain counter and watchdog.
module commit_drain_fsm
  import commit_stage_nport_pkg::*;
#(
  parameter int unsigned DrainTimeout = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  serial_kind_e  kind,
  input  logic          dom,
  input  logic          halt,
  input  logic          flush,
  input  logic          no_st_pending,
  output commit_state_e state,
  output logic          done,
  output logic          fence,
  output logic          fence_i,
  output logic          sfence,
  output logic          dom_flush,
  output logic          timeout
);

  localparam int unsigned CW = $clog2(DrainTimeout + 1);
  localparam logic [CW-1:0] LAST = CW'(DrainTimeout - 1);

  commit_state_e state_q, state_d;
  serial_kind_e  kind_q;
  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  assign state   = state_q;
  assign timeout = timeout_q;

  // Next state, drain completion and the one-cycle flush pulses
  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    fence     = 1'b0;
    fence_i   = 1'b0;
    sfence    = 1'b0;
    dom_flush = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = DRAIN;
          else if (dom) state_d = DOMFLUSH;
        end
        DRAIN: begin
          if (!halt && no_st_pending) begin
            done    = 1'b1;
            state_d = IDLE;
            unique case (1'b1)
              kind_q == SK_FENCE_I: fence_i = 1'b1;
              kind_q == SK_SFENCE:  sfence  = 1'b1;
              default:              fence   = 1'b1;
            endcase
          end
        end
        DOMFLUSH: begin
          dom_flush = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, kind latch, saturating drain counter and sticky watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      kind_q    <= SK_FENCE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start && state_q == IDLE && !flush) kind_q <= kind;
      if (state_q == DRAIN && !flush) begin
        if (cnt_q == LAST) timeout_q <= 1'b1;
        cnt_q <= (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
      end
      if (state_d != DRAIN) cnt_q <= '0;
    end
  end

endmodule

// File: rtl/commit_stage_nport.sv
// In-order N-port commit stage.
// Ack chain, exception mux and CSR/LSU/regfile fan-out.
module commit_stage_nport
  import commit_stage_nport_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned DrainTimeout  = 1024
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     halt_i,
  input  logic                                     single_step_i,
  input  logic                                     flush_i,
  input  scoreboard_entry_t [NrCommitPorts-1:0]    commit_instr_i,
  output logic [NrCommitPorts-1:0]                 commit_ack_o,
  output logic [NrCommitPorts-1:0][4:0]            waddr_o,
  output logic [NrCommitPorts-1:0][XLEN-1:0]       wdata_o,
  output logic [NrCommitPorts-1:0]                 we_gpr_o,
  output logic                                     commit_lsu_o,
  input  logic                                     commit_lsu_ready_i,
  input  logic                                     no_st_pending_i,
  output fu_op                                     csr_op_o,
  output logic [XLEN-1:0]                          csr_wdata_o,
  input  logic [XLEN-1:0]                          csr_rdata_i,
  input  exception_t                               csr_exception_i,
  output logic                                     commit_csr_o,
  output logic                                     csr_write_dom_o,
  output logic                                     fence_o,
  output logic                                     fence_i_o,
  output logic                                     sfence_vma_o,
  output logic                                     flush_commit_o,
  output exception_t                               exception_o,
  output logic [$clog2(NrCommitPorts+1)-1:0]       retired_cnt_o,
  output logic                                     drain_timeout_o
);

  localparam int unsigned CntW = $clog2(NrCommitPorts + 1);

  scoreboard_entry_t       e0;
  commit_state_e           state;
  logic                    idle, start, ack0_idle, dom_go;
  logic                    drain_done, fence, fence_i, sfence, dom_flush;
  logic                    barrier;
  logic [NrCommitPorts-1:0] ack;
  logic                    unused_bits;

  assign e0          = commit_instr_i[0];
  assign idle        = (state == IDLE);
  assign start       = idle && e0.valid && !e0.ex.valid
                    && is_serial(e0.op) && !halt_i;
  assign dom_go      = ack0_idle && e0.chg_dom;
  assign unused_bits = ^commit_instr_i;

  commit_drain_fsm #(
    .DrainTimeout(DrainTimeout)
  ) u_drain (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .start        (start),
    .kind         (to_kind(e0.op)),
    .dom          (dom_go),
    .halt         (halt_i),
    .flush        (flush_i),
    .no_st_pending(no_st_pending_i),
    .state        (state),
    .done         (drain_done),
    .fence        (fence),
    .fence_i      (fence_i),
    .sfence       (sfence),
    .dom_flush    (dom_flush),
    .timeout      (drain_timeout_o)
  );

  // Port 0 retires a non-fence entry from IDLE when nothing blocks it
  always_comb begin
    ack0_idle = idle && e0.valid && !e0.ex.valid && !halt_i
             && !csr_exception_i.valid && !flush_i && !is_serial(e0.op);
    if (e0.fu == STORE) ack0_idle = ack0_idle && commit_lsu_ready_i;
  end

  // In-order ack chain; upper ports only take simple results
  always_comb begin
    ack     = '0;
    barrier = 1'b0;
    ack[0]  = ack0_idle || drain_done;
    for (int i = 1; i < NrCommitPorts; i++) begin
      barrier = barrier || is_barrier(commit_instr_i[i-1]);
      ack[i]  = ack[i-1] && commit_instr_i[i].valid
             && !commit_instr_i[i].ex.valid
             && fu_simple(commit_instr_i[i].fu)
             && !barrier && !single_step_i && !flush_i;
    end
  end

  // Regfile, LSU and CSR side; everything reads idle during reset
  always_comb begin
    commit_ack_o    = '0;
    we_gpr_o        = '0;
    waddr_o         = '0;
    wdata_o         = '0;
    commit_lsu_o    = 1'b0;
    commit_csr_o    = 1'b0;
    csr_op_o        = ADD;
    csr_wdata_o     = '0;
    csr_write_dom_o = 1'b0;
    if (rst_ni) begin
      commit_ack_o = ack;
      we_gpr_o     = ack;
      for (int i = 0; i < NrCommitPorts; i++) begin
        waddr_o[i] = commit_instr_i[i].rd;
        wdata_o[i] = commit_instr_i[i].result;
      end
      if (e0.fu == CSR) wdata_o[0] = csr_rdata_i;
      commit_lsu_o    = ack0_idle && (e0.fu == STORE);
      commit_csr_o    = ack0_idle && (e0.fu == CSR);
      csr_write_dom_o = dom_go;
      if (dom_go) begin
        csr_wdata_o = XLEN'(e0.data_dom);
      end else if (commit_csr_o) begin
        csr_op_o    = e0.op;
        csr_wdata_o = e0.result;
      end
    end
  end

  // Entry exception wins; CSR exception borrows the entry's tval
  always_comb begin
    exception_o = '0;
    if (rst_ni && e0.valid && idle && !halt_i) begin
      if (e0.ex.valid) begin
        exception_o = e0.ex;
      end else begin
        exception_o      = csr_exception_i;
        exception_o.tval = e0.ex.tval;
      end
    end
  end

  assign fence_o        = rst_ni && fence;
  assign fence_i_o      = rst_ni && fence_i;
  assign sfence_vma_o   = rst_ni && sfence;
  assign flush_commit_o = rst_ni && dom_flush;

  // Retire count of the previous cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) retired_cnt_o <= '0;
    else retired_cnt_o <= CntW'($countones(commit_ack_o));
  end

endmodule
